// File: rtl/ysyx_22040365_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings,
// decoder class codes, reset PC and instruction width.
package ysyx_22040365_seq_ctrl_pkg;

    localparam int          INST_W           = 32;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] INST_ILLEGAL = 2'b00;
    localparam logic [1:0] INST_ALU_I   = 2'b01;
    localparam logic [1:0] INST_EBREAK  = 2'b10;

    function automatic logic [63:0] next_pc(input logic [63:0] cur_pc);
        return cur_pc + 64'd4;
    endfunction

endpackage

// File: rtl/ysyx_22040365_fetch_timer.sv
// Fetch wait counter: counts enabled cycles since the last clear and flags
// the cycle on which the LIMIT-th enabled cycle occurs.
module ysyx_22040365_fetch_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Fires during the LIMIT-th enabled cycle so the caller can leave on that edge.
    assign expire = enable && (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ysyx_22040365_seq_ctrl.sv
// Multi-cycle sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH ...,
// halting on ebreak, illegal class or fetch timeout. Optional performance
// counters are enabled by defining YSYX_22040365_PERF_CNT_EN.
module ysyx_22040365_seq_ctrl
    import ysyx_22040365_seq_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ifu_req,
    output logic [63:0]       ifu_addr,
    input  logic              ifu_rvalid,
    input  logic [INST_W-1:0] ifu_rdata,
    output logic [INST_W-1:0] inst,
    input  logic [1:0]        inst_type,
    output logic              ren_rs1,
    output logic              wen_rd,
    output logic [63:0]       pc,
    output logic              halt,
    output logic              illegal,
    output logic              fetch_err
`ifdef YSYX_22040365_PERF_CNT_EN
    ,
    output logic [63:0]       cycle_cnt,
    output logic [63:0]       instret_cnt
`endif
);

    state_t            state_reg, state_next;
    logic [63:0]       pc_reg;
    logic [INST_W-1:0] inst_reg;
    logic              illegal_reg, fetch_err_reg;
    logic              illegal_set, fetch_err_set;
    logic              timer_clear, timer_enable, timer_expire;

    assign timer_clear  = (state_reg != ST_FETCH);
    assign timer_enable = (state_reg == ST_FETCH) && !ifu_rvalid;

    ysyx_22040365_fetch_timer #(
        .LIMIT (FETCH_TIMEOUT)
    ) u_fetch_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= RESET_PC;
            inst_reg      <= '0;
            illegal_reg   <= 1'b0;
            fetch_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH && ifu_rvalid) begin
                inst_reg <= ifu_rdata;
            end
            if (state_reg == ST_WB) begin
                pc_reg <= next_pc(pc_reg);
            end
            if (illegal_set) begin
                illegal_reg <= 1'b1;
            end
            if (fetch_err_set) begin
                fetch_err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        illegal_set   = 1'b0;
        fetch_err_set = 1'b0;
        ifu_req       = 1'b0;
        ren_rs1       = 1'b0;
        wen_rd        = 1'b0;
        halt          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ifu_req = 1'b1;
                // Data arriving on the expiry cycle still counts as a hit.
                if (ifu_rvalid) begin
                    state_next = ST_DECODE;
                end else if (timer_expire) begin
                    state_next    = ST_HALT;
                    fetch_err_set = 1'b1;
                end
            end
            ST_DECODE: begin
                case (inst_type)
                    INST_ALU_I:  state_next = ST_EXEC;
                    INST_EBREAK: state_next = ST_HALT;
                    default: begin
                        state_next  = ST_HALT;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            ST_EXEC: begin
                ren_rs1    = 1'b1;
                state_next = ST_WB;
            end
            ST_WB: begin
                wen_rd     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ifu_addr  = pc_reg;
    assign pc        = pc_reg;
    assign inst      = inst_reg;
    assign illegal   = illegal_reg;
    assign fetch_err = fetch_err_reg;

`ifdef YSYX_22040365_PERF_CNT_EN
    logic [63:0] cycle_cnt_reg, instret_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            if (state_reg != ST_IDLE && state_reg != ST_HALT) begin
                cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
            end
            if (state_reg == ST_WB) begin
                instret_cnt_reg <= instret_cnt_reg + 64'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_ysyx_22040365_seq_ctrl.sv
// Self-checking bench for ysyx_22040365_seq_ctrl: scoreboard of fetched
// {pc, inst} pairs checked at each writeback pulse, plus halt scenarios.
module tb_ysyx_22040365_seq_ctrl;

    localparam logic [63:0] RST_PC   = 64'h8000_0000;
    localparam logic [63:0] RST_PC_B = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        ifu_rvalid = 1'b0;
    logic [31:0] ifu_rdata = 32'h0;
    logic [1:0]  inst_type = 2'b01;

    logic        ifu_req, ren_rs1, wen_rd, halt, illegal, fetch_err;
    logic [63:0] ifu_addr, pc;
    logic [31:0] inst;
    logic        ifu_req_b, ren_rs1_b, wen_rd_b, halt_b, illegal_b, fetch_err_b;
    logic [63:0] ifu_addr_b, pc_b;
    logic [31:0] inst_b;
`ifdef YSYX_22040365_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt, cycle_cnt_b, instret_cnt_b;
`endif

    int passed = 0;
    int total  = 0;
    logic [63:0] pc_model;
    logic [95:0] sb_q[$];

    always #5 clk = ~clk;

    ysyx_22040365_seq_ctrl #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ifu_req(ifu_req), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .inst(inst), .inst_type(inst_type),
        .ren_rs1(ren_rs1), .wen_rd(wen_rd), .pc(pc), .halt(halt), .illegal(illegal),
        .fetch_err(fetch_err)
`ifdef YSYX_22040365_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    ysyx_22040365_seq_ctrl #(.RESET_PC(RST_PC_B), .FETCH_TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .ifu_req(ifu_req_b), .ifu_addr(ifu_addr_b),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .inst(inst_b), .inst_type(inst_type),
        .ren_rs1(ren_rs1_b), .wen_rd(wen_rd_b), .pc(pc_b), .halt(halt_b), .illegal(illegal_b),
        .fetch_err(fetch_err_b)
`ifdef YSYX_22040365_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt_b), .instret_cnt(instret_cnt_b)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; start_b = 0; ifu_rvalid = 0;
        rst = 1;
        step();
        rst = 0;
        pc_model = RST_PC;
    endtask

    // Entry: current cycle is the first FETCH cycle of this instruction.
    task automatic fetch_and_check(input int waits, input logic [31:0] word);
        int lat;
        bit seen;
        bit prev_ren;
        logic [95:0] exp;
        lat = 0; seen = 0; prev_ren = 0;
        for (int i = 0; i < waits; i++) begin
            ifu_rvalid = 0;
            total++;
            if (ifu_req !== 1'b1 || ifu_addr !== pc_model)
                $display("FAIL wait_fetch: req=%b addr=%h, required req=1 addr=%h", ifu_req, ifu_addr, pc_model);
            else passed++;
            step(); lat++;
        end
        ifu_rvalid = 1; ifu_rdata = word;
        sb_q.push_back({pc_model, word});
        step(); lat++;
        ifu_rvalid = 1'b1; ifu_rdata = $urandom;  // ignored outside FETCH
        while (!seen && lat < waits + 10) begin
            if (wen_rd === 1'b1) seen = 1;
            else begin prev_ren = ren_rs1; step(); lat++; end
        end
        ifu_rvalid = 0;
        total++;
        if (!seen) begin
            $display("FAIL wb_timeout: wen_rd not seen within %0d cycles", waits + 10);
        end else if (sb_q.size() == 0) begin
            $display("FAIL wb_spurious: wen_rd with empty scoreboard");
        end else begin
            exp = sb_q.pop_front();
            if (pc !== exp[95:32] || inst !== exp[31:0] || lat != waits + 3 || prev_ren !== 1'b1 || ren_rs1 !== 1'b0)
                $display("FAIL wb: pc=%h inst=%h lat=%0d ren_prev=%b ren=%b, required pc=%h inst=%h lat=%0d ren_prev=1 ren=0",
                         pc, inst, lat, prev_ren, ren_rs1, exp[95:32], exp[31:0], waits + 3);
            else passed++;
        end
        pc_model = pc_model + 64'd4;
        step();
        total++;
        if (ifu_req !== 1'b1 || ifu_addr !== pc_model || wen_rd !== 1'b0)
            $display("FAIL refetch: req=%b addr=%h wen=%b, required req=1 addr=%h wen=0", ifu_req, ifu_addr, wen_rd, pc_model);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        total++;
        if (ifu_req !== 0 || pc !== RST_PC || inst !== 0 || halt !== 0 || illegal !== 0 ||
            fetch_err !== 0 || wen_rd !== 0 || ren_rs1 !== 0)
            $display("FAIL reset_state: req=%b pc=%h inst=%h halt=%b ill=%b ferr=%b", ifu_req, pc, inst, halt, illegal, fetch_err);
        else passed++;
        rst = 0;
        pc_model = RST_PC;
        start = 1; step(); start = 0;
        step();
        total++;
        if (ifu_req !== 1'b1) $display("FAIL fetch_entry: req=%b, required 1", ifu_req);
        else passed++;
        #2 rst = 1;
        #1;
        total++;
        if (ifu_req !== 0 || pc !== RST_PC) $display("FAIL async_reset: req=%b pc=%h, required req=0 pc=%h", ifu_req, pc, RST_PC);
        else passed++;
        rst = 0;
        step();
        total++;
        if (ifu_req !== 0 || pc !== RST_PC) $display("FAIL reset_idle: req=%b pc=%h, required req=0 pc=%h", ifu_req, pc, RST_PC);
        else passed++;
    endtask

    task automatic test_zero_wait();
        inst_type = 2'b01;
        start = 1; step(); start = 0;
        fetch_and_check(0, 32'h0010_0093);
    endtask

    task automatic test_wait3();
        inst_type = 2'b01;
        fetch_and_check(3, 32'h0050_8113);
    endtask

    task automatic test_back_to_back();
        inst_type = 2'b01;
        fetch_and_check(0, 32'h0011_0193);
        fetch_and_check(1, 32'hFFF1_8213);
        fetch_and_check(0, 32'h0002_0293);
    endtask

    task automatic test_ebreak();
        do_reset();
        start = 1; step(); start = 0;
        inst_type = 2'b10;
        ifu_rvalid = 1; ifu_rdata = 32'h0010_0073;
        step(); ifu_rvalid = 0;
        total++;
        if (wen_rd !== 0 || halt !== 0) $display("FAIL ebreak_decode: wen=%b halt=%b, required 0 0", wen_rd, halt);
        else passed++;
        step();
        start = 1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (halt !== 1 || illegal !== 0 || fetch_err !== 0 || wen_rd !== 0 || ifu_req !== 0 || pc !== RST_PC)
                $display("FAIL ebreak_halt: halt=%b ill=%b ferr=%b wen=%b req=%b pc=%h", halt, illegal, fetch_err, wen_rd, ifu_req, pc);
            else passed++;
            step();
        end
        start = 0;
    endtask

    task automatic test_illegal();
        for (int t = 0; t < 2; t++) begin
            do_reset();
            start = 1; step(); start = 0;
            inst_type = (t == 0) ? 2'b00 : 2'b11;
            ifu_rvalid = 1; ifu_rdata = 32'hFFFF_FFFF;
            step(); ifu_rvalid = 0;
            step();
            total++;
            if (halt !== 1 || illegal !== 1 || fetch_err !== 0 || wen_rd !== 0)
                $display("FAIL illegal_halt: type=%b halt=%b ill=%b ferr=%b, required 1 1 0", inst_type, halt, illegal, fetch_err);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        inst_type = 2'b01;
        start = 1; step(); start = 0;
        for (int i = 1; i <= 16; i++) begin
            total++;
            if (ifu_req !== 1 || halt !== 0)
                $display("FAIL timeout_wait: cycle=%0d req=%b halt=%b, required 1 0", i, ifu_req, halt);
            else passed++;
            step();
        end
        total++;
        if (halt !== 1 || fetch_err !== 1 || illegal !== 0 || ifu_req !== 0)
            $display("FAIL timeout_halt: halt=%b ferr=%b ill=%b req=%b, required 1 1 0 0", halt, fetch_err, illegal, ifu_req);
        else passed++;
        // Data on the 16th cycle must win over the timeout.
        do_reset();
        start = 1; step(); start = 0;
        fetch_and_check(15, 32'h0000_0013);
        total++;
        if (halt !== 0 || fetch_err !== 0) $display("FAIL timeout_edge: halt=%b ferr=%b, required 0 0", halt, fetch_err);
        else passed++;
    endtask

    task automatic test_pc_wrap();
        bit seen;
        do_reset();
        inst_type = 2'b01;
        start_b = 1; step(); start_b = 0;
        total++;
        if (ifu_req_b !== 1 || ifu_addr_b !== RST_PC_B || ifu_req !== 0)
            $display("FAIL wrap_fetch: req_b=%b addr_b=%h req_a=%b, required 1 %h 0", ifu_req_b, ifu_addr_b, ifu_req, RST_PC_B);
        else passed++;
        ifu_rvalid = 1; ifu_rdata = 32'h0010_0093;
        step(); ifu_rvalid = 0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (wen_rd_b === 1'b1) seen = 1; else step();
        end
        step();
        total++;
        if (!seen || pc_b !== 64'h0 || ifu_addr_b !== 64'h0 || ifu_req_b !== 1)
            $display("FAIL pc_wrap: seen=%b pc=%h addr=%h req=%b, required 1 0 0 1", seen, pc_b, ifu_addr_b, ifu_req_b);
        else passed++;
    endtask

`ifdef YSYX_22040365_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        inst_type = 2'b01;
        start = 1; step(); start = 0;
        for (int i = 0; i < 3; i++) fetch_and_check(0, 32'h0010_0093 + i);
        total++;
        if (instret_cnt !== 64'd3 || cycle_cnt !== 64'd12)
            $display("FAIL perf_cnt: instret=%0d cycle=%0d, required 3 12", instret_cnt, cycle_cnt);
        else passed++;
    endtask
`endif

    initial begin
        pc_model = RST_PC;
        test_reset();
        test_zero_wait();
        test_wait3();
        test_back_to_back();
        test_ebreak();
        test_illegal();
        test_timeout();
        test_pc_wrap();
`ifdef YSYX_22040365_PERF_CNT_EN
        test_perf();
`endif
        total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
